// File: rtl/alu_sequencer.sv
// Instruction sequencer for the shared alu: queues instructions, issues one at a time,
// writes results back to the regA/regB operand pair and returns each result on a response port.
module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_data,
    input  logic        init_we,
    input  logic        init_sel,
    input  logic [31:0] init_data,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [2:0]  res_flags,
    output logic        res_err,
    output logic [15:0] exec_count,
    output logic        busy
);

    // state | meaning
    // IDLE  | nothing in flight; direct register loads accepted when the queue is empty
    // EXEC  | queue head driven to the alu; result captured and written back at the edge
    // RESP  | captured result held on the response port until consumed
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [31:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] head;
    logic        empty, full, push, pop;

    logic [31:0] reg_a, reg_b;
    logic        do_exec, do_init;

    logic [5:0]  opcode, funct;
    logic        supported, wb_en, wb_slt, wb_dst;
    logic [31:0] wb_val;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push        = instr_valid && !full;
    assign instr_ready = !full;
    assign head        = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= instr_data;
    end

    assign opcode = head[31:26];
    assign funct  = head[5:0];

    // Writeback policy per opcode/funct; overflowing signed adds/subs keep the old value.
    always_comb begin
        supported = 1'b0;
        wb_en     = 1'b0;
        wb_slt    = 1'b0;
        wb_dst    = (opcode == 6'h00) ? head[11] : head[16];
        if (opcode == 6'h00) begin
            case (funct)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27: begin
                    supported = 1'b1;
                    wb_en     = 1'b1;
                end
                6'h20, 6'h22: begin
                    supported = 1'b1;
                    wb_en     = !alu_flags[0];
                end
                6'h2A, 6'h2B: begin
                    supported = 1'b1;
                    wb_en     = 1'b1;
                    wb_slt    = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (opcode)
                6'h04, 6'h05, 6'h23, 6'h2B: supported = 1'b1;
                6'h08: begin
                    supported = 1'b1;
                    wb_en     = !alu_flags[0];
                end
                6'h09, 6'h0C, 6'h0D, 6'h0E: begin
                    supported = 1'b1;
                    wb_en     = 1'b1;
                end
                6'h0A, 6'h0B: begin
                    supported = 1'b1;
                    wb_en     = 1'b1;
                    wb_slt    = 1'b1;
                end
                default: ;
            endcase
        end
        wb_val = wb_slt ? {31'b0, alu_flags[1]} : alu_result;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = empty ? IDLE : EXEC;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_instr = '0;
        res_valid = 1'b0;
        pop       = 1'b0;
        do_exec   = 1'b0;
        do_init   = 1'b0;
        case (state)
            IDLE: do_init = empty && init_we;
            EXEC: begin
                alu_instr = head;
                pop       = 1'b1;
                do_exec   = 1'b1;
            end
            RESP: res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a      <= '0;
            reg_b      <= '0;
            res_data   <= '0;
            res_flags  <= '0;
            res_err    <= 1'b0;
            exec_count <= '0;
        end else if (do_exec) begin
            res_data   <= alu_result;
            res_flags  <= alu_flags;
            res_err    <= !supported;
            exec_count <= exec_count + 16'd1;
            if (wb_en && !wb_dst) reg_a <= wb_val;
            if (wb_en && wb_dst)  reg_b <= wb_val;
        end else if (do_init) begin
            if (init_sel) reg_b <= init_data;
            else          reg_a <= init_data;
        end
    end

    assign alu_regA = reg_a;
    assign alu_regB = reg_b;
    assign busy     = (state != IDLE) || !empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: provides a behavioural alu, runs directed vectors and corner
// sequences, then random traffic against a transaction-level reference model.
module tb_alu_sequencer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data;
    logic        init_we, init_sel;
    logic [31:0] init_data;
    logic [31:0] alu_instr, alu_regA, alu_regB, alu_result;
    logic [2:0]  alu_flags;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_flags;
    logic        res_err;
    logic [15:0] exec_count;
    logic        busy;

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .init_we(init_we), .init_sel(init_sel), .init_data(init_data),
        .alu_instr(alu_instr), .alu_regA(alu_regA), .alu_regB(alu_regB),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags), .res_err(res_err),
        .exec_count(exec_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    typedef enum int {
        M_BAD, M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_ADD, M_ADDU, M_SUB, M_SUBU,
        M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_BEQ, M_BNE, M_ADDI, M_ADDIU, M_SLTI,
        M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LW, M_SW
    } mn_t;

    typedef struct packed {
        logic [31:0] a, b, ins, d;
        logic [2:0]  f;
        logic        e;
        logic [31:0] na, nb;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  f;
        logic        e;
        logic [31:0] na, nb;
    } exp_t;

    vec_t       vt [12];
    exp_t       q [$];
    logic [5:0] rfun [16];
    logic [5:0] iop [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mn_t mnem(input logic [31:0] ins);
        mn_t m;
        m = M_BAD;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h00: m = M_SLL;   6'h02: m = M_SRL;   6'h03: m = M_SRA;
                6'h04: m = M_SLLV;  6'h06: m = M_SRLV;  6'h07: m = M_SRAV;
                6'h20: m = M_ADD;   6'h21: m = M_ADDU;  6'h22: m = M_SUB;
                6'h23: m = M_SUBU;  6'h24: m = M_AND;   6'h25: m = M_OR;
                6'h26: m = M_XOR;   6'h27: m = M_NOR;   6'h2A: m = M_SLT;
                6'h2B: m = M_SLTU;
                default: m = M_BAD;
            endcase
        end else begin
            case (ins[31:26])
                6'h04: m = M_BEQ;   6'h05: m = M_BNE;   6'h08: m = M_ADDI;
                6'h09: m = M_ADDIU; 6'h0A: m = M_SLTI;  6'h0B: m = M_SLTIU;
                6'h0C: m = M_ANDI;  6'h0D: m = M_ORI;   6'h0E: m = M_XORI;
                6'h23: m = M_LW;    6'h2B: m = M_SW;
                default: m = M_BAD;
            endcase
        end
        return m;
    endfunction

    // Behavioural alu: returns {zero, negative, overflow, result}; negative is the true sign.
    function automatic logic [34:0] alu_model(input logic [31:0] ins, input logic [31:0] a,
                                              input logic [31:0] b);
        mn_t m;
        logic [31:0] o, r;
        logic neg, ovf;
        logic [4:0] sh;
        m = mnem(ins);
        sh = ins[10:6];
        ovf = 1'b0;
        if (ins[31:26] == 6'h00 || m == M_BEQ || m == M_BNE) o = b;
        else if (m == M_ANDI || m == M_ORI || m == M_XORI) o = {16'h0, ins[15:0]};
        else o = {{16{ins[15]}}, ins[15:0]};
        case (m)
            M_SLL:  r = b << sh;
            M_SRL:  r = b >> sh;
            M_SRA:  r = $signed(b) >>> sh;
            M_SLLV: r = b << a[4:0];
            M_SRLV: r = b >> a[4:0];
            M_SRAV: r = $signed(b) >>> a[4:0];
            M_ADD, M_ADDU, M_ADDI, M_ADDIU, M_LW, M_SW: r = a + o;
            M_SUB, M_SUBU, M_SLT, M_SLTU, M_SLTI, M_SLTIU, M_BEQ, M_BNE: r = a - o;
            M_AND, M_ANDI: r = a & o;
            M_OR, M_ORI:   r = a | o;
            M_XOR, M_XORI: r = a ^ o;
            M_NOR:         r = ~(a | o);
            default:       r = 32'h0;
        endcase
        if (m == M_ADD || m == M_ADDI) ovf = (a[31] == o[31]) && (r[31] != a[31]);
        if (m == M_SUB || m == M_SLT || m == M_SLTI) ovf = (a[31] != o[31]) && (r[31] != a[31]);
        neg = r[31] ^ ovf;
        if (m == M_SLTU || m == M_SLTIU) neg = (a < o);
        return {(r == 32'h0), neg, ovf, r};
    endfunction

    always_comb begin
        {alu_flags, alu_result} = alu_model(alu_instr, alu_regA, alu_regB);
    end

    function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b);
        exp_t x;
        mn_t m;
        logic [34:0] af;
        logic wb;
        logic [31:0] v;
        m = mnem(ins);
        af = alu_model(ins, a, b);
        x.d = af[31:0];
        x.f = af[34:32];
        x.e = (m == M_BAD);
        x.na = a;
        x.nb = b;
        wb = 1'b1;
        v = x.d;
        case (m)
            M_BAD, M_BEQ, M_BNE, M_LW, M_SW: wb = 1'b0;
            M_ADD, M_SUB, M_ADDI: wb = !x.f[0];
            M_SLT, M_SLTU, M_SLTI, M_SLTIU: v = {31'b0, x.f[1]};
            default: ;
        endcase
        if (wb) begin
            if ((ins[31:26] == 6'h00) ? ins[11] : ins[16]) x.nb = v;
            else x.na = v;
        end
        return x;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        int sel, idx;
        x = $urandom;
        sel = $urandom_range(0, 3);
        if (sel == 1) begin
            idx = $urandom_range(0, 15);
            x[31:26] = 6'h00;
            x[5:0] = rfun[idx];
        end else if (sel >= 2) begin
            idx = $urandom_range(0, 10);
            x[31:26] = iop[idx];
        end
        return x;
    endfunction

    task automatic set_regs(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); init_we = 1'b1; init_sel = 1'b0; init_data = a;
        @(negedge clk); init_sel = 1'b1; init_data = b;
        @(negedge clk); init_we = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: res_valid timeout got 0 expected 1", name);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        logic [31:0] seen;
        set_regs(v.a, v.b);
        chk("vec_ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr_data = v.ins;
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        seen = '0;
        while (!res_valid && lat < 12) begin
            if (alu_instr != 32'h0) seen = alu_instr;
            @(negedge clk);
            lat++;
        end
        exp_count++;
        chk("vec_latency", lat, 32'd3);
        chk("vec_alu_instr", seen, v.ins);
        chk("vec_res_data", res_data, v.d);
        chk("vec_res_flags", 32'(res_flags), 32'(v.f));
        chk("vec_res_err", 32'(res_err), 32'(v.e));
        chk("vec_regA", alu_regA, v.na);
        chk("vec_regB", alu_regB, v.nb);
        chk("vec_exec_count", 32'(exec_count), 32'(exp_count[15:0]));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("vec_release", 32'({busy, res_valid}), 32'd0);
    endtask

    function automatic vec_t mkv(input logic [31:0] a, b, ins, d, input logic [2:0] f,
                                 input logic e, input logic [31:0] na, nb);
        vec_t v;
        v.a = a; v.b = b; v.ins = ins; v.d = d; v.f = f; v.e = e; v.na = na; v.nb = nb;
        return v;
    endfunction

    initial begin
        int acc, got, pos;
        exp_t x;

        rfun = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        iop  = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};

        vt[0]  = mkv(32'd5, 32'd7, 32'h00010020, 32'd12, 3'b000, 1'b0, 32'd12, 32'd7);
        vt[1]  = mkv(32'h7FFFFFFF, 32'h11, 32'h20010001, 32'h80000000, 3'b001, 1'b0,
                     32'h7FFFFFFF, 32'h11);
        vt[2]  = mkv(32'hFFFFFFFF, 32'd1, 32'h0001082A, 32'hFFFFFFFE, 3'b010, 1'b0,
                     32'hFFFFFFFF, 32'd1);
        vt[3]  = mkv(32'd3, 32'd3, 32'h10010000, 32'd0, 3'b100, 1'b0, 32'd3, 32'd3);
        vt[4]  = mkv(32'd3, 32'd3, 32'hFC000000, 32'd0, 3'b100, 1'b1, 32'd3, 32'd3);
        vt[5]  = mkv(32'd10, 32'd3, 32'h00010822, 32'd7, 3'b000, 1'b0, 32'd10, 32'd7);
        vt[6]  = mkv(32'd1, 32'hFFFFFFFF, 32'h0001002B, 32'd2, 3'b010, 1'b0, 32'd1, 32'hFFFFFFFF);
        vt[7]  = mkv(32'hF0F00000, 32'd0, 32'h34010F0F, 32'hF0F00F0F, 3'b010, 1'b0,
                     32'hF0F00000, 32'hF0F00F0F);
        vt[8]  = mkv(32'd0, 32'h11, 32'h00010100, 32'h110, 3'b000, 1'b0, 32'h110, 32'h11);
        vt[9]  = mkv(32'h100, 32'd5, 32'h8C010010, 32'h110, 3'b000, 1'b0, 32'h100, 32'd5);
        vt[10] = mkv(32'h7FFFFFFF, 32'd1, 32'h00010820, 32'h80000000, 3'b001, 1'b0,
                     32'h7FFFFFFF, 32'd1);
        vt[11] = mkv(32'd6, 32'd9, 32'h00010001, 32'd0, 3'b100, 1'b1, 32'd6, 32'd9);

        rst = 1'b1; instr_valid = 1'b0; instr_data = '0; init_we = 1'b0; init_sel = 1'b0;
        init_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_flags_err", 32'({res_flags, res_err}), 32'd0);
        chk("rst_exec_count", 32'(exec_count), 32'd0);
        chk("rst_regs", alu_regA | alu_regB, 32'd0);
        chk("rst_alu_instr", alu_instr, 32'd0);

        for (int i = 0; i < 12; i++) run_vec(vt[i]);

        // Back-to-back dependent adds: second sees the first's writeback, 2-cycle spacing.
        set_regs(32'd1, 32'd2);
        res_ready = 1'b1;
        @(negedge clk); instr_valid = 1'b1; instr_data = 32'h00010020;
        @(negedge clk);
        @(negedge clk); instr_valid = 1'b0;
        pos = 2;
        got = 0;
        while (got < 2 && pos < 20) begin
            if (res_valid) begin
                chk("b2b_pos", pos, (got == 0) ? 32'd3 : 32'd5);
                chk("b2b_data", res_data, (got == 0) ? 32'd3 : 32'd5);
                got++;
            end
            @(negedge clk);
            pos++;
        end
        chk("b2b_count", got, 32'd2);
        exp_count += 2;
        res_ready = 1'b0;

        // Backpressure: queue fills, response held, late init ignored, then in-order drain.
        set_regs(32'd1, 32'd1);
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            init_we = (c >= 3);
            init_sel = 1'b0;
            init_data = 32'hDEADBEEF;
            instr_valid = (acc < DEPTH + 2);
            instr_data = 32'h00010021;
            if (instr_valid && instr_ready) acc++;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        chk("bp_accepted", acc, DEPTH + 1);
        chk("bp_instr_ready", 32'(instr_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_data", res_data, 32'd2);
            @(negedge clk);
        end
        init_we = 1'b0;
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < DEPTH + 1; c++) begin
            if (res_valid) begin
                chk("bp_order", res_data, 32'(2 + got));
                got++;
            end
            @(negedge clk);
        end
        exp_count += DEPTH + 1;
        chk("bp_drained", got, DEPTH + 1);
        chk("bp_exec_count", 32'(exec_count), 32'(exp_count[15:0]));
        chk("bp_regA", alu_regA, 32'd6);
        chk("bp_regB", alu_regB, 32'd1);
        res_ready = 1'b0;

        // Reset while a response is pending and the queue still holds work.
        set_regs(32'd9, 32'd4);
        @(negedge clk); instr_valid = 1'b1; instr_data = 32'h00010021;
        @(negedge clk);
        @(negedge clk); instr_valid = 1'b0;
        wait_valid("rst_mid_wait");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstm_res_valid", 32'(res_valid), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        chk("rstm_regA", alu_regA, 32'd0);
        chk("rstm_regB", alu_regB, 32'd0);
        chk("rstm_exec_count", 32'(exec_count), 32'd0);
        chk("rstm_instr_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        chk("rstm_flushed", 32'({busy, res_valid}), 32'd0);

        // Random traffic against the transaction-level model.
        begin
            logic [31:0] ma, mb;
            int mcount;
            ma = '0;
            mb = '0;
            mcount = 0;
            for (int c = 0; c < 700; c++) begin
                @(negedge clk);
                instr_valid = ($urandom_range(0, 2) != 0);
                instr_data = rand_instr();
                res_ready = ($urandom_range(0, 3) != 0);
                init_we = ($urandom_range(0, 4) == 0);
                init_sel = 1'($urandom_range(0, 1));
                init_data = $urandom;
                if (init_we && !busy) begin
                    if (init_sel) mb = init_data;
                    else ma = init_data;
                end
                if (res_valid && res_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd_unexpected: got response %h expected none", res_data);
                    end else begin
                        x = q.pop_front();
                        mcount++;
                        chk("rnd_data", res_data, x.d);
                        chk("rnd_flags", 32'(res_flags), 32'(x.f));
                        chk("rnd_err", 32'(res_err), 32'(x.e));
                        chk("rnd_regA", alu_regA, x.na);
                        chk("rnd_regB", alu_regB, x.nb);
                        chk("rnd_exec_count", 32'(exec_count), 32'(mcount[15:0]));
                    end
                end
                if (instr_valid && instr_ready) begin
                    x = ref_exec(instr_data, ma, mb);
                    q.push_back(x);
                    ma = x.na;
                    mb = x.nb;
                end
            end
            @(negedge clk);
            instr_valid = 1'b0;
            init_we = 1'b0;
            res_ready = 1'b1;
            for (int c = 0; c < 60 && q.size() > 0; c++) begin
                if (res_valid) begin
                    x = q.pop_front();
                    mcount++;
                    chk("drn_data", res_data, x.d);
                    chk("drn_flags_err", 32'({res_flags, res_err}), 32'({x.f, x.e}));
                    chk("drn_regs", alu_regA ^ alu_regB, x.na ^ x.nb);
                    chk("drn_exec_count", 32'(exec_count), 32'(mcount[15:0]));
                end
                @(negedge clk);
            end
            @(negedge clk);
            chk("drn_left", q.size(), 32'd0);
            chk("drn_busy", 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
